// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack controller: opcodes, trap codes,
// operand type tags, controller states and the stored entry layout.
package operand_stack_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_POP2    = 3'd3;
  localparam logic [2:0] OP_REPLACE = 3'd4;
  localparam logic [2:0] OP_DROP    = 3'd5;

  localparam logic [2:0] TRAP_NONE      = 3'd0;
  localparam logic [2:0] TRAP_UNDERFLOW = 3'd1;
  localparam logic [2:0] TRAP_OVERFLOW  = 3'd2;
  localparam logic [2:0] TRAP_BAD_OP    = 3'd3;

  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [1:0] TYPE_I64 = 2'd1;
  localparam logic [1:0] TYPE_F32 = 2'd2;
  localparam logic [1:0] TYPE_F64 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH_NOS,
    ST_REFILL,
    ST_TRAPPED
  } state_t;

  typedef struct packed {
    logic [1:0]  tag;
    logic [63:0] value;
  } entry_t;

endpackage

// File: rtl/operand_stack_ram.sv
// Storage for stack entries below TOS: one write port and one registered
// (synchronous) read port. The controller never reads and writes the same word.
module operand_stack_ram
  import operand_stack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/operand_stack_ctrl.sv
// Operand stack sequencer: TOS held in registers, deeper entries in
// operand_stack_ram; pops return operands on a one-cycle pop_valid pulse.
module operand_stack_ctrl
  import operand_stack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [63:0]      push_value,
  input  logic [1:0]       push_type,
  output logic             pop_valid,
  output logic [63:0]      a_value,
  output logic [1:0]       a_type,
  output logic [63:0]      b_value,
  output logic [1:0]       b_type,
  output logic [63:0]      result,
  output logic [1:0]       result_type,
  output logic             result_empty,
  output logic [CNT_W-1:0] depth,
  output logic [2:0]       trap
);

  localparam int AW = $clog2(DEPTH);

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [63:0]      tos, tos_next;
  logic [1:0]       tos_type, tos_type_next;
  logic             pop_valid_q, pop_valid_next;
  logic [63:0]      a_q, a_next, b_q, b_next;
  logic [1:0]       a_type_q, a_type_next, b_type_q, b_type_next;
  logic [2:0]       trap_q, trap_next;

  logic             ram_we, ram_re;
  logic [AW-1:0]    ram_waddr, ram_raddr;
  entry_t           ram_wdata, ram_rdata;

  operand_stack_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_next     = state;
    count_next     = count;
    tos_next       = tos;
    tos_type_next  = tos_type;
    pop_valid_next = 1'b0;
    a_next         = a_q;
    a_type_next    = a_type_q;
    b_next         = b_q;
    b_type_next    = b_type_q;
    trap_next      = trap_q;
    ram_we         = 1'b0;
    ram_waddr      = AW'(count - CNT_W'(1));
    ram_wdata      = '{tag: tos_type, value: tos};
    ram_re         = 1'b0;
    ram_raddr      = AW'(count - CNT_W'(2));

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: ;
            OP_PUSH: begin
              if (count == CNT_W'(DEPTH)) begin
                trap_next  = TRAP_OVERFLOW;
                state_next = ST_TRAPPED;
              end else begin
                ram_we        = (count != '0);
                tos_next      = push_value;
                tos_type_next = push_type;
                count_next    = count + CNT_W'(1);
              end
            end
            OP_POP, OP_DROP: begin
              if (count == '0) begin
                trap_next  = TRAP_UNDERFLOW;
                state_next = ST_TRAPPED;
              end else begin
                if (cmd_op == OP_POP) begin
                  pop_valid_next = 1'b1;
                  b_next         = tos;
                  b_type_next    = tos_type;
                end
                count_next = count - CNT_W'(1);
                // The new TOS comes from RAM one cycle later unless the stack empties.
                if (count > CNT_W'(1)) begin
                  ram_re     = 1'b1;
                  state_next = ST_REFILL;
                end else begin
                  tos_next      = '0;
                  tos_type_next = TYPE_I32;
                end
              end
            end
            OP_POP2: begin
              if (count < CNT_W'(2)) begin
                trap_next  = TRAP_UNDERFLOW;
                state_next = ST_TRAPPED;
              end else begin
                ram_re     = 1'b1;
                state_next = ST_FETCH_NOS;
              end
            end
            OP_REPLACE: begin
              if (count == '0) begin
                trap_next  = TRAP_UNDERFLOW;
                state_next = ST_TRAPPED;
              end else begin
                pop_valid_next = 1'b1;
                b_next         = tos;
                b_type_next    = tos_type;
                tos_next       = push_value;
                tos_type_next  = push_type;
              end
            end
            default: begin
              trap_next  = TRAP_BAD_OP;
              state_next = ST_TRAPPED;
            end
          endcase
        end
      end
      ST_FETCH_NOS: begin
        pop_valid_next = 1'b1;
        a_next         = ram_rdata.value;
        a_type_next    = ram_rdata.tag;
        b_next         = tos;
        b_type_next    = tos_type;
        count_next     = count - CNT_W'(2);
        if (count > CNT_W'(2)) begin
          ram_re     = 1'b1;
          ram_raddr  = AW'(count - CNT_W'(3));
          state_next = ST_REFILL;
        end else begin
          tos_next      = '0;
          tos_type_next = TYPE_I32;
          state_next    = ST_IDLE;
        end
      end
      ST_REFILL: begin
        tos_next      = ram_rdata.value;
        tos_type_next = ram_rdata.tag;
        state_next    = ST_IDLE;
      end
      ST_TRAPPED: ;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      tos         <= '0;
      tos_type    <= TYPE_I32;
      pop_valid_q <= 1'b0;
      a_q         <= '0;
      a_type_q    <= TYPE_I32;
      b_q         <= '0;
      b_type_q    <= TYPE_I32;
      trap_q      <= TRAP_NONE;
    end else begin
      state       <= state_next;
      count       <= count_next;
      tos         <= tos_next;
      tos_type    <= tos_type_next;
      pop_valid_q <= pop_valid_next;
      a_q         <= a_next;
      a_type_q    <= a_type_next;
      b_q         <= b_next;
      b_type_q    <= b_type_next;
      trap_q      <= trap_next;
    end
  end

  assign cmd_ready    = (state == ST_IDLE);
  assign pop_valid    = pop_valid_q;
  assign a_value      = a_q;
  assign a_type       = a_type_q;
  assign b_value      = b_q;
  assign b_type       = b_type_q;
  assign result       = tos;
  assign result_type  = tos_type;
  assign result_empty = (count == '0);
  assign depth        = count;
  assign trap         = trap_q;

endmodule
